// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST frame assembler.
// Holds the default frame geometry (pixels per frame, label field width,
// pixel width), the resulting image word width, and the assembler FSM
// state encoding.
package mnist_pkg;
  localparam int NPIX      = 784;          // 28x28, row-major
  localparam int NCLASS    = 10;           // one-hot label field width
  localparam int PIX_W     = 8;            // grayscale pixel width
  localparam int IMG_W     = NPIX + NCLASS; // 794-bit frame word
  localparam int CNT_W     = 10;           // pixel counter width
  localparam int MAX_LABEL = 9;            // highest legal class index

  typedef enum logic [1:0] {
    S_LABEL = 2'd0,
    S_PIX   = 2'd1,
    S_OUT   = 2'd2
  } state_t;
endpackage

// File: rtl/mnist_onehot_dec.sv
// 4-bit class index to NCLASS-wide one-hot decoder.
// Indices with no matching output bit decode to all zeros.
// Ports:
//   idx    : input  class index
//   onehot : output one-hot field, bit i set when idx == i
module mnist_onehot_dec #(
  parameter int NCLASS = 10
) (
  input  logic [3:0]        idx,
  output logic [NCLASS-1:0] onehot
);
  for (genvar i = 0; i < NCLASS; i++) begin : g_bit
    assign onehot[i] = (int'(idx) == i);
  end
endmodule

// File: rtl/mnist_frame_assembler.sv
// Assembles one MNIST training frame: a one-hot label followed by NPIX
// binarized pixels, presented as a single NPIX+NCLASS bit word.
// Flow: S_LABEL takes one label, S_PIX takes NPIX pixels, S_OUT holds the
// word until the consumer takes it. No double buffering: nothing is
// accepted while the frame is being presented.
// Optional feature: define MNIST_FRAME_CNT_EN to add frame_cnt[15:0], a
// wrapping count of delivered frames.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   flush           : synchronous abort, returns to S_LABEL
//   bin_threshold   : pixel binarization level (pix >= thr -> 1)
//   label_valid/label/label_ready : label handshake
//   pix_valid/pix_data/pix_ready  : pixel handshake
//   image_data      : frame word, label one-hot in [NCLASS-1:0]
//   img_valid/img_ready : frame handshake
//   label_err       : latched label was out of range (> 9)
//   frame_cnt       : delivered frame count (MNIST_FRAME_CNT_EN only)
module mnist_frame_assembler
  import mnist_pkg::*;
#(
  parameter int NPIX   = mnist_pkg::NPIX,
  parameter int NCLASS = mnist_pkg::NCLASS,
  parameter int PIX_W  = mnist_pkg::PIX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [PIX_W-1:0]       bin_threshold,
  input  logic                   label_valid,
  input  logic [3:0]             label,
  output logic                   label_ready,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   pix_ready,
  output logic [NPIX+NCLASS-1:0] image_data,
`ifdef MNIST_FRAME_CNT_EN
  output logic [15:0]            frame_cnt,
`endif
  output logic                   img_valid,
  input  logic                   img_ready,
  output logic                   label_err
);
  localparam int W     = NPIX + NCLASS;
  localparam int IDX_W = $clog2(W);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [NCLASS-1:0] onehot;
  logic             lbl_hs, pix_hs, out_hs, last_pix;
  logic [IDX_W-1:0] wr_idx;

  mnist_onehot_dec #(.NCLASS(NCLASS)) u_dec (
    .idx    (label),
    .onehot (onehot)
  );

  // All handshake outputs are pure decodes of the registered state.
  assign label_ready = (state == S_LABEL);
  assign pix_ready   = (state == S_PIX);
  assign img_valid   = (state == S_OUT);

  // flush beats any coinciding handshake.
  assign lbl_hs   = label_valid && label_ready && !flush;
  assign pix_hs   = pix_valid   && pix_ready   && !flush;
  assign out_hs   = img_valid   && img_ready   && !flush;
  assign last_pix = (cnt == CNT_W'(NPIX - 1));
  assign wr_idx   = IDX_W'(NCLASS) + IDX_W'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LABEL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_LABEL;
    end else begin
      case (state)
        S_LABEL: if (lbl_hs)             state_nxt = S_PIX;
        S_PIX:   if (pix_hs && last_pix) state_nxt = S_OUT;
        S_OUT:   if (out_hs)             state_nxt = S_LABEL;
        default:                         state_nxt = S_LABEL;
      endcase
    end
  end

  // Frame word is never cleared between frames: every bit is rewritten
  // (label field on the label handshake, each pixel bit once) before the
  // next presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_data <= '0;
      label_err  <= 1'b0;
      cnt        <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (lbl_hs) begin
        image_data[NCLASS-1:0] <= onehot;
        label_err              <= (label > 4'(MAX_LABEL));
        cnt                    <= '0;
      end
      if (pix_hs) begin
        image_data[wr_idx] <= (pix_data >= bin_threshold);
        cnt                <= cnt + 1'b1;
      end
    end
  end

`ifdef MNIST_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      frame_cnt <= '0;
    else if (out_hs) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mnist_frame_assembler.sv
// Self-checking bench for mnist_frame_assembler. Expected frames are built
// while stimulus is driven, pushed to a scoreboard and compared when the
// block presents its frame word.
module tb_mnist_frame_assembler;
  localparam int NPIX   = 784;
  localparam int NCLASS = 10;
  localparam int PIX_W  = 8;
  localparam int W      = NPIX + NCLASS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [PIX_W-1:0] bin_threshold = '0;
  logic             label_valid = 1'b0;
  logic [3:0]       label = '0;
  logic             label_ready;
  logic             pix_valid = 1'b0;
  logic [PIX_W-1:0] pix_data = '0;
  logic             pix_ready;
  logic [W-1:0]     image_data;
  logic             img_valid;
  logic             img_ready = 1'b0;
  logic             label_err;
`ifdef MNIST_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  typedef struct {
    logic [W-1:0] img;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  always #5 clk = ~clk;

  mnist_frame_assembler #(.NPIX(NPIX), .NCLASS(NCLASS), .PIX_W(PIX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bin_threshold (bin_threshold),
    .label_valid   (label_valid),
    .label         (label),
    .label_ready   (label_ready),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .image_data    (image_data),
`ifdef MNIST_FRAME_CNT_EN
    .frame_cnt     (frame_cnt),
`endif
    .img_valid     (img_valid),
    .img_ready     (img_ready),
    .label_err     (label_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // mode 0: alternating 0x00/0xFF, thr 0x80; mode 1: random data and thr;
  // mode 2: random data, thr 0. Pushes an expectation only for full frames.
  task automatic send_frame(input logic [3:0] l, input int mode, input bit gaps, input int npix);
    logic [W-1:0]     e;
    logic [PIX_W-1:0] d, t;
    int               n;
    e = '0;
    if (l <= 4'd9) e[l] = 1'b1;
    @(negedge clk);
    label_valid = 1'b1;
    label       = l;
    n = 0;
    while (!label_ready && n < 2000) begin @(negedge clk); n++; end
    chk("label_ready_wait", W'(label_ready), W'(1));
    @(posedge clk);
    for (int k = 0; k < npix; k++) begin
      @(negedge clk);
      label_valid = 1'b0;
      if (gaps && ($urandom % 4 == 0)) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      case (mode)
        0:       begin d = (k % 2 == 1) ? 8'hFF : 8'h00; t = 8'h80; end
        1:       begin d = PIX_W'($urandom); t = PIX_W'($urandom); end
        default: begin d = PIX_W'($urandom); t = '0; end
      endcase
      pix_valid     = 1'b1;
      pix_data      = d;
      bin_threshold = t;
      n = 0;
      while (!pix_ready && n < 100) begin @(negedge clk); n++; end
      if (!pix_ready) begin
        chk("pix_ready_wait", W'(pix_ready), W'(1));
        break;
      end
      e[NCLASS + k] = (d >= t);
      @(posedge clk);
    end
    @(negedge clk);
    pix_valid   = 1'b0;
    label_valid = 1'b0;
    if (npix == NPIX) begin
      chk("img_valid_latency", W'(img_valid), W'(1));
      sb.push_back('{img: e, err: (l > 4'd9)});
    end
  endtask

  // Wait for a frame, compare with the scoreboard, hold img_ready low for
  // 'hold' cycles while offering labels/pixels, then take the frame.
  task automatic recv_frame(input int hold);
    exp_t ex;
    int   n;
    n = 0;
    while (!img_valid && n < 3000) begin @(negedge clk); n++; end
    chk("img_valid_wait", W'(img_valid), W'(1));
    if (!img_valid) return;
    chk("sb_nonempty", W'(sb.size() != 0), W'(1));
    if (sb.size() == 0) return;
    ex = sb.pop_front();
    chk("image_data", image_data, ex.img);
    chk("label_err", W'(label_err), W'(ex.err));
    pix_valid   = 1'b1;
    pix_data    = 8'hFF;
    label_valid = 1'b1;
    label       = 4'd0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_image", image_data, ex.img);
      chk("hold_pix_ready", W'(pix_ready), W'(0));
      chk("hold_label_ready", W'(label_ready), W'(0));
      chk("hold_img_valid", W'(img_valid), W'(1));
    end
    pix_valid   = 1'b0;
    label_valid = 1'b0;
    img_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    img_ready = 1'b0;
    n_out++;
    chk("taken_img_valid", W'(img_valid), W'(0));
    chk("taken_label_ready", W'(label_ready), W'(1));
`ifdef MNIST_FRAME_CNT_EN
    chk("frame_cnt", W'(frame_cnt), W'(n_out[15:0]));
`endif
  endtask

  initial begin
    exp_t dropped;
    // reset state
    #3;
    chk("rst_label_ready", W'(label_ready), W'(1));
    chk("rst_pix_ready", W'(pix_ready), W'(0));
    chk("rst_img_valid", W'(img_valid), W'(0));
    chk("rst_image_data", image_data, '0);
    chk("rst_label_err", W'(label_err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // label 6, alternating pixels, threshold 0x80
    send_frame(4'd6, 0, 1'b0, NPIX);
    chk("onehot_6", W'(image_data[NCLASS-1:0]), W'(10'h040));
    recv_frame(0);

    // random data/threshold with gaps, consumer stalls 20 cycles
    send_frame(4'd3, 1, 1'b1, NPIX);
    recv_frame(20);

    // out-of-range label, threshold 0 -> all pixel bits set
    send_frame(4'd12, 2, 1'b0, NPIX);
    recv_frame(2);

    // flush coinciding with pixel 400
    send_frame(4'd4, 1, 1'b0, 400);
    pix_valid = 1'b1;
    pix_data  = 8'hFF;
    flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    pix_valid = 1'b0;
    chk("flush_label_ready", W'(label_ready), W'(1));
    chk("flush_pix_ready", W'(pix_ready), W'(0));
    chk("flush_img_valid", W'(img_valid), W'(0));
    send_frame(4'd5, 0, 1'b1, NPIX);
    recv_frame(1);

    // flush while presenting: output handshake discarded
    send_frame(4'd7, 1, 1'b0, NPIX);
    img_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    img_ready = 1'b0;
    flush     = 1'b0;
    chk("flush_out_img_valid", W'(img_valid), W'(0));
    chk("flush_out_label_ready", W'(label_ready), W'(1));
`ifdef MNIST_FRAME_CNT_EN
    chk("flush_out_frame_cnt", W'(frame_cnt), W'(n_out[15:0]));
`endif
    if (sb.size() != 0) dropped = sb.pop_back();

    // async reset at pixel 500 of a frame with an out-of-range label
    send_frame(4'd12, 1, 1'b0, 500);
    chk("pre_rst_label_err", W'(label_err), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_label_ready", W'(label_ready), W'(1));
    chk("mid_rst_pix_ready", W'(pix_ready), W'(0));
    chk("mid_rst_img_valid", W'(img_valid), W'(0));
    chk("mid_rst_image_data", image_data, '0);
    chk("mid_rst_label_err", W'(label_err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MNIST_FRAME_CNT_EN
    n_out = 0;
`endif
    repeat (10) @(negedge clk);
    chk("post_rst_img_valid", W'(img_valid), W'(0));

    // a clean frame after reset
    send_frame(4'd9, 1, 1'b1, NPIX);
    recv_frame(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
